mux4_rr_arb: RTL and testbench
==============================

# mux4_rr_arb

Round-robin arbiter and output register that sits directly upstream of the team's 4:1 mux stage. It picks one of four requesters with 4-bit payloads every cycle and acknowledges the winner. It presents the selected word on a registered valid/ready output. It drives the select code in the same encoding the team's `mux4`/`mux4s` consume, so a downstream mux4 fed with the same d0..d3 reproduces the last selection.

## Interface
- `WIDTH`, default 4: payload width of d0..d3 and y.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req`, in, 4: request per source; `req[i]` qualifies `di`.
- `d0`, `d1`, `d2`, `d3`, in, WIDTH each: source payloads, held stable while the matching req is high.
- `gnt`, out, 4: combinational one-hot acknowledge; `gnt[i]`=1 means `di` is consumed at this edge.
- `s`, out, 2: registered select code of the word currently in y, in mux4 encoding.
- `y`, out, WIDTH: registered output payload.
- `y_valid`, out, 1: y holds an unconsumed word.
- `y_ready`, in, 1: downstream accepts y at this edge when `y_valid`=1.

## Operation
- Internal state is a 2-bit round-robin pointer `ptr` (highest-priority source index), plus the `y`, `s` and `y_valid` registers.
- The output register is free when `y_valid`=0 or `y_ready`=1, and `load = free && |req`.
- Arbitration: scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4). Winner g is the first index with `req` set.
- `gnt` is one-hot of g when `load`=1, else 0. It is never multi-hot, and it is 0 while `rst_n`=0.
- On load at the clock edge:
  - `y` is set to dg.
  - `s` is set to enc(g).
  - `y_valid` is set to 1.
  - `ptr` is set to (g+1) mod 4, wrapping 3 to 0.
- When free and no req: `y_valid` goes to 0, and `y`, `s` and `ptr` hold.
- When not free (`y_valid`=1 and `y_ready`=0): y, s, y_valid and ptr all hold, `gnt`=0, and requesters keep their requests pending.
- Select encoding enc(i), which matches the team mux4 (s[1] picks the pair, s[0]=1 picks the lower index):
  - source 0 gives 2'b01.
  - source 1 gives 2'b00.
  - source 2 gives 2'b11.
  - source 3 gives 2'b10.
- `ptr` advances only on a grant. An idle cycle does not change priority.

## Timing
- Reset (asynchronous assert, synchronous release): `y`=0, `s`=2'b00, `y_valid`=0, `ptr`=0, `gnt`=0.
- Reset asserted mid-transfer discards the held word immediately. Nothing is granted until the first edge after release.
- Latency: a request granted at edge N appears on y with `y_valid`=1 after edge N, so there is one cycle of latency.
- Throughput: one word per cycle while `y_ready` is held at 1. A simultaneous pop and load replaces y with no bubble.
- `gnt` depends combinationally on `req`, `ptr`, `y_valid` and `y_ready`. It has no dependency on d0..d3.
- Fairness: with all four req held high and `y_ready`=1, grants follow the order 0,1,2,3,0,... Any continuously asserted request is granted within 4 loads.
- `y_ready` while `y_valid`=0 is ignored, apart from freeing the register.

## Test plan
- Reset release:
  - Stimulus: `rst_n` low, with req=4'b1111 and d0..d3 = 1,2,3,4.
  - Required: `gnt`=0, `y_valid`=0, `y`=0, `s`=00.
  - Then: after release, the first edge loads y=1 (d0) with s=01.
- Full rotation:
  - Stimulus: req=1111, `y_ready`=1, d0..d3 = A,B,C,D.
  - Required: `gnt` sequence 0001, 0010, 0100, 1000, 0001.
  - Required: y sequence A,B,C,D,A with s sequence 01,00,11,10,01.
- Backpressure:
  - Stimulus: y loaded with B from source 1, then `y_ready`=0 for 3 cycles with req=1111.
  - Required: `gnt`=0 throughout, and y=B, s=00, `y_valid`=1 hold.
  - Then: on `y_ready`=1, source 2 is granted in the same cycle.
- Sparse requests and wrap:
  - Stimulus: ptr=3 (after a grant to source 2), then req=0101.
  - Required: winner is 0 (wrap from 3), `gnt`=0001, next ptr=1.
  - Then: the next cycle grants source 2.
- Idle and drain:
  - Stimulus: req=0 while `y_valid`=1 and `y_ready`=1.
  - Required: `y_valid` drops to 0 after the edge, and y, s and ptr are unchanged.
- Downstream check:
  - Stimulus: connect a team mux4 with the same d0..d3 and `s`, using random req, d and `y_ready` over 1000 cycles.
  - Required: the mux4 output equals y whenever `y_valid`=1 and the d inputs are stable.
  - Required: `gnt` is never multi-hot.

Source files
------------

// File: rtl/mux4_rr_arb.sv
// mux4_rr_arb: four-way round-robin arbiter feeding a registered
// valid/ready output stage. The select code s uses the same encoding as
// the downstream mux4/mux4s, so that mux reproduces y from d0..d3 and s.
module mux4_rr_arb #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       gnt,
    output logic [1:0]       s,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready
);

    // Round-robin pointer: index of the highest-priority source
    logic [1:0]       ptr;
    logic [1:0]       win;
    logic             free;
    logic             load;
    logic [WIDTH-1:0] win_d;

    // mux4 select encoding: s[1] picks the pair, s[0]=1 picks the lower index
    function automatic logic [1:0] enc(input logic [1:0] idx);
        logic [1:0] code;
        case (idx)
            2'd0:    code = 2'b01;
            2'd1:    code = 2'b00;
            2'd2:    code = 2'b11;
            default: code = 2'b10;
        endcase
        return code;
    endfunction

    // Output register accepts a new word when empty or being popped
    always_comb begin
        free = !y_valid || y_ready;
        load = free && (|req);
    end

    // Winner search: scan from ptr+3 down to ptr so the last hit, i.e. the
    // first requester at or after ptr, is the one that sticks
    always_comb begin
        logic [1:0] idx;
        win = ptr;
        idx = ptr;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr + 2'(3 - k);
            if (req[idx]) begin
                win = idx;
            end
        end
    end

    // One-hot acknowledge, suppressed while reset is asserted
    always_comb begin
        gnt = '0;
        if (load && rst_n) begin
            gnt = 4'b0001 << win;
        end
    end

    // Payload of the winning source
    always_comb begin
        case (win)
            2'd0:    win_d = d0;
            2'd1:    win_d = d1;
            2'd2:    win_d = d2;
            default: win_d = d3;
        endcase
    end

    // Output register and pointer update; pointer moves only on a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y       <= '0;
            s       <= 2'b00;
            y_valid <= 1'b0;
            ptr     <= 2'd0;
        end else if (load) begin
            y       <= win_d;
            s       <= enc(win);
            y_valid <= 1'b1;
            ptr     <= win + 2'd1;
        end else if (free) begin
            y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arb.sv
// Directed and randomised checks for mux4_rr_arb.
module tb_mux4_rr_arb;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req;
    logic [WIDTH-1:0] d0, d1, d2, d3;
    logic [3:0]       gnt;
    logic [1:0]       s;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic             y_ready;

    int n_cmp;
    int n_err;

    mux4_rr_arb #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .d0      (d0),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .gnt     (gnt),
        .s       (s),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Team mux4: s[1] picks the pair, s[0]=1 picks the lower index
    function automatic logic [WIDTH-1:0] mux4(input logic [1:0] sel,
                                              input logic [WIDTH-1:0] a0, a1, a2, a3);
        if (sel[1]) return sel[0] ? a2 : a3;
        else        return sel[0] ? a0 : a1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [WIDTH-1:0] a0, a1, a2, a3);
        d0 = a0; d1 = a1; d2 = a2; d3 = a3;
    endtask

    initial begin
        logic [1:0]       mptr;
        logic             mvalid;
        logic [WIDTH-1:0] my;
        logic [1:0]       ms;
        logic [3:0]       egnt;
        logic [1:0]       ew;
        logic             efree;
        logic             fresh;
        logic [WIDTH-1:0] wd;

        n_cmp = 0;
        n_err = 0;

        // Reset with everything requesting
        rst_n = 1'b0; req = 4'b1111; y_ready = 1'b1;
        set_d(4'd1, 4'd2, 4'd3, 4'd4);
        #3;
        chk("rst_gnt",    gnt, 4'b0000);
        chk("rst_yvalid", y_valid, 1'b0);
        chk("rst_y",      y, 4'd0);
        chk("rst_s",      s, 2'b00);
        step();
        chk("rst_hold_yvalid", y_valid, 1'b0);
        rst_n = 1'b1;
        #3;
        chk("rel_gnt", gnt, 4'b0001);
        step();
        chk("rel_y",      y, 4'd1);
        chk("rel_s",      s, 2'b01);
        chk("rel_yvalid", y_valid, 1'b1);

        // Reset mid-transfer discards the held word at once
        y_ready = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_yvalid", y_valid, 1'b0);
        chk("midrst_y",      y, 4'd0);
        chk("midrst_gnt",    gnt, 4'b0000);
        step();
        rst_n = 1'b1; y_ready = 1'b1;
        set_d(4'hA, 4'hB, 4'hC, 4'hD);

        // Full rotation 0,1,2,3,0
        #3; chk("rot0_gnt", gnt, 4'b0001);
        step(); chk("rot0_y", y, 4'hA); chk("rot0_s", s, 2'b01);
        #3; chk("rot1_gnt", gnt, 4'b0010);
        step(); chk("rot1_y", y, 4'hB); chk("rot1_s", s, 2'b00);
        #3; chk("rot2_gnt", gnt, 4'b0100);
        step(); chk("rot2_y", y, 4'hC); chk("rot2_s", s, 2'b11);
        #3; chk("rot3_gnt", gnt, 4'b1000);
        step(); chk("rot3_y", y, 4'hD); chk("rot3_s", s, 2'b10);
        #3; chk("rot4_gnt", gnt, 4'b0001);
        step(); chk("rot4_y", y, 4'hA); chk("rot4_s", s, 2'b01);

        // Load B from source 1, then stall for three cycles
        #3; chk("bp_load_gnt", gnt, 4'b0010);
        step(); chk("bp_load_y", y, 4'hB); chk("bp_load_s", s, 2'b00);
        y_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3; chk("bp_gnt", gnt, 4'b0000);
            step();
            chk("bp_y", y, 4'hB); chk("bp_s", s, 2'b00); chk("bp_yvalid", y_valid, 1'b1);
        end
        y_ready = 1'b1;
        #3; chk("bp_release_gnt", gnt, 4'b0100);
        step(); chk("bp_release_y", y, 4'hC); chk("bp_release_s", s, 2'b11);

        // ptr=3, sparse request wraps to source 0 then source 2
        req = 4'b0101;
        #3; chk("wrap_gnt", gnt, 4'b0001);
        step(); chk("wrap_y", y, 4'hA); chk("wrap_s", s, 2'b01);
        #3; chk("wrap_next_gnt", gnt, 4'b0100);
        step(); chk("wrap_next_y", y, 4'hC); chk("wrap_next_s", s, 2'b11);

        // Idle drain: valid drops, y/s/ptr hold
        req = 4'b0000;
        #3; chk("idle_gnt", gnt, 4'b0000);
        step();
        chk("idle_yvalid", y_valid, 1'b0);
        chk("idle_y", y, 4'hC);
        chk("idle_s", s, 2'b11);
        req = 4'b1111;
        #3; chk("idle_ptr_gnt", gnt, 4'b1000);
        step(); chk("idle_ptr_y", y, 4'hD); chk("idle_ptr_s", s, 2'b10);

        // Random phase against a reference model and a downstream mux4
        mptr = 2'd0; mvalid = 1'b1; my = 4'hD; ms = 2'b10;
        fresh = 1'b1;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            req     = 4'($urandom_range(0, 15));
            y_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                set_d(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
                fresh = 1'b0;
            end
            efree = !mvalid || y_ready;
            egnt  = 4'b0000;
            ew    = 2'd0;
            if (efree) begin
                for (int k = 3; k >= 0; k--) begin
                    if (req[mptr + 2'(k)]) ew = mptr + 2'(k);
                end
                if (|req) egnt = 4'b0001 << ew;
            end
            #3;
            chk("rnd_gnt", gnt, egnt);
            chk("rnd_onehot", ((gnt & (gnt - 4'd1)) == 4'b0000), 1'b1);
            step();
            if (egnt != 4'b0000) begin
                case (ew)
                    2'd0:    begin wd = d0; ms = 2'b01; end
                    2'd1:    begin wd = d1; ms = 2'b00; end
                    2'd2:    begin wd = d2; ms = 2'b11; end
                    default: begin wd = d3; ms = 2'b10; end
                endcase
                my = wd; mvalid = 1'b1; mptr = ew + 2'd1; fresh = 1'b1;
            end else if (efree) begin
                mvalid = 1'b0;
            end
            chk("rnd_yvalid", y_valid, mvalid);
            chk("rnd_y", y, my);
            chk("rnd_s", s, ms);
            if (y_valid && fresh) begin
                chk("rnd_mux4", mux4(s, d0, d1, d2, d3), y);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
